// File: rtl/mem_stage_ctrl_pkg.sv
// Widths, the FIFO sample record and the memory-stage sync FSM states,
// shared by the memory-stage control logic and anything that models it.
package mem_stage_ctrl_pkg;

    localparam int DATAW      = 32;
    localparam int IMMW       = 11;
    localparam int REGW       = 3;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic             last;
        logic [DATAW-1:0] data;
    } sample_t;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        SYNC_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl_sample_fifo.sv
// Small circular FIFO; the head is read combinationally from registered
// storage so the consumer sees it in the same cycle it becomes valid.
module sample_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign dout  = mem[rd_ptr_reg];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage control: feeds FFT samples through a FIFO, applies config
// writes, registers the writeback bundle and stalls upstream when needed.
module mem_stage_ctrl #(
    parameter int DATAW      = mem_stage_ctrl_pkg::DATAW,
    parameter int IMMW       = mem_stage_ctrl_pkg::IMMW,
    parameter int REGW       = mem_stage_ctrl_pkg::REGW,
    parameter int FIFO_DEPTH = mem_stage_ctrl_pkg::FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fft_wr_en,
    input  logic             reg_wr_en,
    input  logic             p_flag,
    input  logic             syn,
    input  logic             set_en,
    input  logic             set_freq,
    input  logic [REGW-1:0]  wr_reg,
    input  logic [IMMW-1:0]  imm,
    input  logic [DATAW-1:0] ex_data,
    output logic             stall,
    output logic [DATAW-1:0] fft_data,
    output logic             fft_last,
    output logic             fft_valid,
    input  logic             fft_ready,
    input  logic             fft_busy,
    output logic [IMMW-1:0]  freq_cfg,
    output logic [IMMW-1:0]  amp_cfg,
    output logic             wb_reg_wr_en,
    output logic [REGW-1:0]  wb_reg,
    output logic [DATAW-1:0] wb_data
);

    import mem_stage_ctrl_pkg::*;

    localparam logic [0:0] ST_RUN       = RUN;
    localparam logic [0:0] ST_SYNC_WAIT = SYNC_WAIT;

    logic [0:0]       state_reg;
    logic [0:0]       state_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [DATAW:0]   fifo_dout;
    logic             full_stall;
    logic             sync_stall;
    logic             retire;
    logic [IMMW-1:0]  freq_cfg_reg;
    logic [IMMW-1:0]  amp_cfg_reg;
    logic             wb_reg_wr_en_reg;
    logic [REGW-1:0]  wb_reg_reg;
    logic [DATAW-1:0] wb_data_reg;

    sample_fifo #(
        .WIDTH (DATAW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_sample_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({p_flag, ex_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head is forced to zero while empty so stale RAM never leaks out.
    assign fft_valid = ~fifo_empty;
    assign fft_data  = fifo_empty ? '0 : fifo_dout[DATAW-1:0];
    assign fft_last  = ~fifo_empty & fifo_dout[DATAW];
    assign fifo_pop  = fft_valid & fft_ready;

    assign full_stall = fft_wr_en & fifo_full & ~fifo_pop;
    assign sync_stall = (state_reg == ST_SYNC_WAIT)
                      | (syn & (state_reg == ST_RUN) & (fft_valid | fft_busy));
    assign stall      = full_stall | sync_stall;
    assign retire     = ~stall;
    assign fifo_push  = retire & fft_wr_en;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (syn & (fft_valid | fft_busy)) begin
                    state_next = ST_SYNC_WAIT;
                end
            end
            default: begin
                if (fifo_empty & ~fft_busy) begin
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A stalled instruction must not write back twice, so only the enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_cfg_reg     <= '0;
            amp_cfg_reg      <= '0;
            wb_reg_wr_en_reg <= 1'b0;
            wb_reg_reg       <= '0;
            wb_data_reg      <= '0;
        end else begin
            if (retire) begin
                wb_reg_wr_en_reg <= reg_wr_en;
                wb_reg_reg       <= wr_reg;
                wb_data_reg      <= ex_data;
            end else begin
                wb_reg_wr_en_reg <= 1'b0;
            end
            if (retire & set_en) begin
                if (set_freq) begin
                    freq_cfg_reg <= imm;
                end else begin
                    amp_cfg_reg <= imm;
                end
            end
        end
    end

    assign freq_cfg     = freq_cfg_reg;
    assign amp_cfg      = amp_cfg_reg;
    assign wb_reg_wr_en = wb_reg_wr_en_reg;
    assign wb_reg       = wb_reg_reg;
    assign wb_data      = wb_data_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, hand-written stall/reset
// sequences, then constrained-random traffic against a queue-based model.
module tb_mem_stage_ctrl;

    import mem_stage_ctrl_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fft_wr_en, reg_wr_en, p_flag, syn, set_en, set_freq;
    logic [REGW-1:0]  wr_reg;
    logic [IMMW-1:0]  imm;
    logic [DATAW-1:0] ex_data;
    logic             stall;
    logic [DATAW-1:0] fft_data;
    logic             fft_last, fft_valid;
    logic             fft_ready, fft_busy;
    logic [IMMW-1:0]  freq_cfg, amp_cfg;
    logic             wb_reg_wr_en;
    logic [REGW-1:0]  wb_reg;
    logic [DATAW-1:0] wb_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic             wr, rw, pf, sy, se, sf;
        logic [REGW-1:0]  rg;
        logic [IMMW-1:0]  im;
        logic [DATAW-1:0] d;
        logic             rdy, bsy;
    } ins_t;

    typedef struct {
        ins_t             in;
        logic             e_stall, e_valid, e_last;
        logic [DATAW-1:0] e_data;
        logic             e_wben;
        logic [REGW-1:0]  e_wbreg;
        logic [DATAW-1:0] e_wbdata;
        logic [IMMW-1:0]  e_freq, e_amp;
    } vec_t;

    mem_stage_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fft_wr_en    (fft_wr_en),
        .reg_wr_en    (reg_wr_en),
        .p_flag       (p_flag),
        .syn          (syn),
        .set_en       (set_en),
        .set_freq     (set_freq),
        .wr_reg       (wr_reg),
        .imm          (imm),
        .ex_data      (ex_data),
        .stall        (stall),
        .fft_data     (fft_data),
        .fft_last     (fft_last),
        .fft_valid    (fft_valid),
        .fft_ready    (fft_ready),
        .fft_busy     (fft_busy),
        .freq_cfg     (freq_cfg),
        .amp_cfg      (amp_cfg),
        .wb_reg_wr_en (wb_reg_wr_en),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk_ins(input logic wr, rw, pf, sy, se, sf,
                                    input logic [REGW-1:0] rg, input logic [IMMW-1:0] im,
                                    input logic [DATAW-1:0] d, input logic rdy, bsy);
        ins_t x;
        x.wr = wr; x.rw = rw; x.pf = pf; x.sy = sy; x.se = se; x.sf = sf;
        x.rg = rg; x.im = im; x.d = d; x.rdy = rdy; x.bsy = bsy;
        return x;
    endfunction

    function automatic vec_t mk_vec(input ins_t in, input logic st, va, input logic [DATAW-1:0] da,
                                    input logic la, wbe, input logic [REGW-1:0] wbr,
                                    input logic [DATAW-1:0] wbd, input logic [IMMW-1:0] fq, am);
        vec_t v;
        v.in = in; v.e_stall = st; v.e_valid = va; v.e_data = da; v.e_last = la;
        v.e_wben = wbe; v.e_wbreg = wbr; v.e_wbdata = wbd; v.e_freq = fq; v.e_amp = am;
        return v;
    endfunction

    task automatic drive(input ins_t x);
        fft_wr_en = x.wr; reg_wr_en = x.rw; p_flag = x.pf; syn = x.sy;
        set_en = x.se; set_freq = x.sf; wr_reg = x.rg; imm = x.im; ex_data = x.d;
        fft_ready = x.rdy; fft_busy = x.bsy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    sample_t          m_q[$];
    bit               m_wait;
    logic [IMMW-1:0]  m_freq, m_amp;
    logic             m_wben;
    logic [REGW-1:0]  m_wbreg;
    logic [DATAW-1:0] m_wbdata;

    vec_t tbl [8];

    initial begin
        ins_t x;
        ins_t cur;
        bit   have;
        int   rp;

        drive(mk_ins(0, 0, 0, 0, 0, 0, 3'd0, 11'd0, 32'd0, 1'b0, 1'b0));

        // Reset state
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_valid", fft_valid, 0);
        chk("rst_data", fft_data, 0);
        chk("rst_last", fft_last, 0);
        chk("rst_freq", freq_cfg, 0);
        chk("rst_amp", amp_cfg, 0);
        chk("rst_wben", wb_reg_wr_en, 0);
        chk("rst_wbreg", wb_reg, 0);
        chk("rst_wbdata", wb_data, 0);
        rst_n = 1'b1;
        next_cycle();

        // Directed table: streaming, config writes, writeback, free syn
        tbl[0] = mk_vec(mk_ins(1,0,0,0,0,0,3'd0,11'h0,32'h11,1,0),       0,0,32'h0,0, 0,3'd0,32'h0,         11'h0,11'h0);
        tbl[1] = mk_vec(mk_ins(1,0,0,0,0,0,3'd0,11'h0,32'h22,1,0),       0,1,32'h11,0,0,3'd0,32'h11,        11'h0,11'h0);
        tbl[2] = mk_vec(mk_ins(1,0,1,0,0,0,3'd0,11'h0,32'h33,1,0),       0,1,32'h22,0,0,3'd0,32'h22,        11'h0,11'h0);
        tbl[3] = mk_vec(mk_ins(0,0,0,0,1,1,3'd0,11'h2AB,32'h0,1,0),      0,1,32'h33,1,0,3'd0,32'h33,        11'h0,11'h0);
        tbl[4] = mk_vec(mk_ins(0,0,0,0,1,0,3'd0,11'h7FF,32'h0,1,0),      0,0,32'h0,0, 0,3'd0,32'h0,         11'h2AB,11'h0);
        tbl[5] = mk_vec(mk_ins(0,1,0,0,0,0,3'd5,11'h0,32'hDEADBEEF,1,0), 0,0,32'h0,0, 0,3'd0,32'h0,         11'h2AB,11'h7FF);
        tbl[6] = mk_vec(mk_ins(0,0,0,0,0,0,3'd0,11'h0,32'h0,1,0),        0,0,32'h0,0, 1,3'd5,32'hDEADBEEF, 11'h2AB,11'h7FF);
        tbl[7] = mk_vec(mk_ins(0,0,0,1,0,0,3'd0,11'h0,32'h0,1,0),        0,0,32'h0,0, 0,3'd0,32'h0,         11'h2AB,11'h7FF);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].in);
            @(negedge clk);
            chk("tbl_stall", stall, tbl[i].e_stall);
            chk("tbl_valid", fft_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                chk("tbl_data", fft_data, tbl[i].e_data);
                chk("tbl_last", fft_last, tbl[i].e_last);
            end
            chk("tbl_wben", wb_reg_wr_en, tbl[i].e_wben);
            chk("tbl_wbreg", wb_reg, tbl[i].e_wbreg);
            chk("tbl_wbdata", wb_data, tbl[i].e_wbdata);
            chk("tbl_freq", freq_cfg, tbl[i].e_freq);
            chk("tbl_amp", amp_cfg, tbl[i].e_amp);
            $display("vec %0d: stall=%0b valid=%0b data=%h last=%0b wb=%0b/%0d/%h freq=%h amp=%h",
                     i, stall, fft_valid, fft_data, fft_last, wb_reg_wr_en, wb_reg, wb_data, freq_cfg, amp_cfg);
            next_cycle();
        end

        // Fill FIFO with fft_ready=0, ninth push must stall and hold WB
        for (int i = 0; i < DEPTH; i++) begin
            drive(mk_ins(1, 1, 0, 0, 0, 0, 3'(i), 11'd0, 32'h100 + 32'(i), 1'b0, 1'b0));
            @(negedge clk);
            chk("fill_stall", stall, 0);
            next_cycle();
        end
        drive(mk_ins(1, 1, 1, 0, 0, 0, 3'd6, 11'd0, 32'h108, 1'b0, 1'b0));
        @(negedge clk);
        chk("full_stall", stall, 1);
        chk("full_wben0", wb_reg_wr_en, 1);
        chk("full_wbreg0", wb_reg, 7);
        chk("full_wbdata0", wb_data, 32'h107);
        next_cycle();
        @(negedge clk);
        chk("full_stall2", stall, 1);
        chk("full_wben_held", wb_reg_wr_en, 0);
        chk("full_wbreg_held", wb_reg, 7);
        chk("full_wbdata_held", wb_data, 32'h107);
        $display("seq full: ninth push stalled, wb held");
        next_cycle();
        fft_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_push_stall", stall, 0);
        chk("full_head", fft_data, 32'h100);
        next_cycle();
        drive(mk_ins(0, 0, 0, 0, 0, 0, 3'd0, 11'd0, 32'd0, 1'b1, 1'b0));
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            chk("drain_valid", fft_valid, 1);
            chk("drain_data", fft_data, 32'h100 + 32'(k));
            chk("drain_last", fft_last, (k == DEPTH) ? 1'b1 : 1'b0);
            if (k == 1) begin
                chk("ninth_wben", wb_reg_wr_en, 1);
                chk("ninth_wbreg", wb_reg, 6);
                chk("ninth_wbdata", wb_data, 32'h108);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("drain_empty", fft_valid, 0);
        $display("seq full: drained in order");
        next_cycle();

        // Sync barrier: two samples queued and FFT busy
        drive(mk_ins(1, 0, 0, 0, 0, 0, 3'd0, 11'd0, 32'h201, 1'b0, 1'b0));
        next_cycle();
        drive(mk_ins(1, 0, 1, 0, 0, 0, 3'd0, 11'd0, 32'h202, 1'b0, 1'b0));
        next_cycle();
        drive(mk_ins(0, 0, 0, 1, 0, 0, 3'd0, 11'd0, 32'd0, 1'b0, 1'b1));
        @(negedge clk);
        chk("syn_enter_stall", stall, 1);
        next_cycle();
        fft_ready = 1'b1;
        @(negedge clk);
        chk("syn_stall_a", stall, 1);
        chk("syn_head_a", fft_data, 32'h201);
        chk("syn_wben", wb_reg_wr_en, 0);
        next_cycle();
        @(negedge clk);
        chk("syn_stall_b", stall, 1);
        chk("syn_head_b", fft_data, 32'h202);
        next_cycle();
        @(negedge clk);
        chk("syn_stall_busy", stall, 1);
        chk("syn_empty", fft_valid, 0);
        next_cycle();
        fft_busy = 1'b0;
        @(negedge clk);
        chk("syn_stall_last", stall, 1);
        next_cycle();
        @(negedge clk);
        chk("syn_release", stall, 0);
        $display("seq syn: barrier released after drain and idle");
        next_cycle();

        // Async reset mid-stream
        drive(mk_ins(0, 0, 0, 0, 1, 1, 3'd0, 11'h155, 32'd0, 1'b0, 1'b0));
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            drive(mk_ins(1, 0, 0, 0, 0, 0, 3'd0, 11'd0, 32'h301 + 32'(i), 1'b0, 1'b0));
            next_cycle();
        end
        @(negedge clk);
        drive(mk_ins(0, 0, 0, 0, 0, 0, 3'd0, 11'd0, 32'd0, 1'b0, 1'b0));
        chk("pre_rst_freq", freq_cfg, 11'h155);
        chk("pre_rst_valid", fft_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", fft_valid, 0);
        chk("arst_data", fft_data, 0);
        chk("arst_stall", stall, 0);
        chk("arst_freq", freq_cfg, 0);
        chk("arst_amp", amp_cfg, 0);
        chk("arst_wbdata", wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive(mk_ins(1, 0, 0, 0, 0, 0, 3'd0, 11'd0, 32'h3AB, 1'b0, 1'b0));
        @(negedge clk);
        chk("post_rst_valid0", fft_valid, 0);
        next_cycle();
        drive(mk_ins(0, 0, 0, 0, 0, 0, 3'd0, 11'd0, 32'd0, 1'b0, 1'b0));
        @(negedge clk);
        chk("post_rst_valid", fft_valid, 1);
        chk("post_rst_head", fft_data, 32'h3AB);
        chk("post_rst_last", fft_last, 0);
        $display("seq reset: FIFO flushed, new head 3ab");

        // Randomized traffic against the model, starting from reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_wait = 0; m_freq = '0; m_amp = '0; m_wben = 0; m_wbreg = '0; m_wbdata = '0;
        have = 0;
        rp = 5;
        next_cycle();
        for (int c = 0; c < 1500; c++) begin
            int  n;
            bit  pop, e_stall;
            if (c % 100 == 0) rp = $urandom_range(1, 9);
            if (!have) begin
                cur.wr = ($urandom_range(0, 1) == 1);
                cur.sy = !cur.wr && ($urandom_range(0, 11) == 0);
                cur.rw = $urandom_range(0, 1) == 1;
                cur.pf = $urandom_range(0, 3) == 0;
                cur.se = $urandom_range(0, 4) == 0;
                cur.sf = $urandom_range(0, 1) == 1;
                cur.rg = REGW'($urandom);
                cur.im = IMMW'($urandom);
                cur.d  = DATAW'($urandom);
            end
            cur.rdy = ($urandom_range(0, 9) < rp);
            cur.bsy = ($urandom_range(0, 9) < 2);
            drive(cur);
            @(negedge clk);
            n = m_q.size();
            pop = (n != 0) && cur.rdy;
            e_stall = m_wait || (cur.sy && (n != 0 || cur.bsy)) || (cur.wr && n == DEPTH && !pop);
            chk("rnd_stall", stall, e_stall);
            chk("rnd_valid", fft_valid, n != 0);
            if (n != 0) begin
                chk("rnd_data", fft_data, m_q[0].data);
                chk("rnd_last", fft_last, m_q[0].last);
            end
            chk("rnd_freq", freq_cfg, m_freq);
            chk("rnd_amp", amp_cfg, m_amp);
            chk("rnd_wben", wb_reg_wr_en, m_wben);
            chk("rnd_wbreg", wb_reg, m_wbreg);
            chk("rnd_wbdata", wb_data, m_wbdata);
            @(posedge clk);
            if (m_wait) begin
                if (n == 0 && !cur.bsy) m_wait = 0;
            end else if (cur.sy && (n != 0 || cur.bsy)) begin
                m_wait = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (!e_stall) begin
                if (cur.wr) m_q.push_back('{last: cur.pf, data: cur.d});
                if (cur.se) begin
                    if (cur.sf) m_freq = cur.im;
                    else m_amp = cur.im;
                end
                m_wben = cur.rw; m_wbreg = cur.rg; m_wbdata = cur.d;
                $display("retire %0d: wr=%0b syn=%0b set=%0b rw=%0b reg=%0d data=%h fifo=%0d",
                         c, cur.wr, cur.sy, cur.se, cur.rw, cur.rg, cur.d, m_q.size());
            end else begin
                m_wben = 0;
            end
            have = e_stall;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Pushes fft_wr_en samples into a small FIFO that feeds the FFT engine over a valid/ready interface.
- Applies set_en config writes and registers the writeback bundle for the MEM/WB stage.
- Generates the stall back to the upstream pipe registers when the FIFO is full or a syn barrier is pending.

Parameters:
- DATAW, 32, data width of ex_data and FFT samples
- IMMW, 11, immediate/config width
- REGW, 3, register index width
- FIFO_DEPTH, 8, sample FIFO entries (power of 2, at least 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fft_wr_en  in  1  instruction writes ex_data as an FFT sample
- reg_wr_en  in  1  instruction writes register file
- p_flag  in  1  sample is last of frame; forwarded as fft_last
- syn  in  1  sync barrier: wait until FFT drained and idle
- set_en  in  1  config write from imm
- set_freq  in  1  config target: 1 = freq_cfg, 0 = amp_cfg
- wr_reg  in  REGW  destination register
- imm  in  IMMW  immediate
- ex_data  in  DATAW  execute result / sample
- stall  out  1  to IF/ID/EX/MEM pipe registers, hold
- fft_data  out  DATAW  FIFO head sample
- fft_last  out  1  FIFO head last flag
- fft_valid  out  1  FIFO non-empty
- fft_ready  in  1  FFT accepts head
- fft_busy  in  1  FFT engine processing
- freq_cfg  out  IMMW  frequency config register
- amp_cfg  out  IMMW  amplitude config register
- wb_reg_wr_en  out  1  registered reg_wr_en to MEM/WB
- wb_reg  out  REGW  registered wr_reg
- wb_data  out  DATAW  registered ex_data

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, FIFO empty, state RUN.
  - freq_cfg = 0, amp_cfg = 0.
- The current input instruction "retires" in a cycle when stall=0. All side effects occur only on retire:
  - FIFO push
  - cfg write
  - WB register update
- stall (combinational):
  - (fft_wr_en & full & !(fft_valid & fft_ready)) | (state==SYNC_WAIT) | (syn & state==RUN & (fft_valid | fft_busy)).
  - A pop in the same cycle frees a slot, so push into a full FIFO with a simultaneous pop does not stall.
- FIFO:
  - Entries are {p_flag, ex_data}.
  - Push on retire & fft_wr_en; pop on fft_valid & fft_ready.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - fft_data/fft_last/fft_valid reflect the head combinationally from registered storage.
  - Head must stay stable while fft_valid=1 and fft_ready=0.
- FSM:
  - RUN:
    - If syn and (fft_valid | fft_busy): go to SYNC_WAIT; the instruction does not retire.
    - If syn and FIFO empty and !fft_busy: retire immediately, zero-cycle stall.
  - SYNC_WAIT:
    - When FIFO empty and fft_busy=0, go to RUN; stall drops the next cycle and syn retires then.
    - Minimum stall is 1 cycle when entering SYNC_WAIT.
- Config:
  - On retire & set_en: set_freq ? freq_cfg <= imm : amp_cfg <= imm.
  - Update visible the cycle after retire.
- Writeback:
  - On retire: wb_reg_wr_en <= reg_wr_en, wb_reg <= wr_reg, wb_data <= ex_data.
  - When stalled: wb_reg_wr_en <= 0, with wb_reg and wb_data held, so no duplicate writeback.
  - Latency is 1 cycle.
- Other rules:
  - An instruction with both fft_wr_en and syn is illegal; behaviour is undefined and the bench must not drive it.
  - Reset mid-frame discards FIFO contents. fft_valid drops immediately (async).

Decomposition:
- Shared pipeline package:
  - Constants DATAW/IMMW/REGW.
  - Typedef sample_t (struct {logic last; logic [DATAW-1:0] data;}).
  - Enum mem_state_t {RUN, SYNC_WAIT}.
- One sub-module: sample_fifo, parameterised on width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-low reset.

Test Plan:
- Push 3 samples (0x11, 0x22, 0x33 with p_flag on last), fft_ready=1 → fft_data 0x11, 0x22, 0x33 on consecutive cycles; fft_last=1 only with 0x33; stall stays 0.
- fft_ready=0, push 9 samples with FIFO_DEPTH=8:
  - Expected: 9th sees stall=1 and WB bundle held with wb_reg_wr_en=0.
  - Raise fft_ready: 9th retires the same cycle; FIFO order is preserved.
- FIFO holds 2 entries, fft_busy=1, syn issued:
  - Expected: stall=1 until FIFO drains and fft_busy falls; stall drops 1 cycle later.
  - syn with FIFO empty and fft_busy=0 → no stall.
- set_en=1, set_freq=1, imm=0x2AB → freq_cfg=0x2AB next cycle, amp_cfg unchanged.
  - Then set_freq=0, imm=0x7FF → amp_cfg=0x7FF.
- reg_wr_en=1, wr_reg=5, ex_data=0xDEADBEEF → next cycle wb_reg_wr_en=1, wb_reg=5, wb_data=0xDEADBEEF.
- FIFO 5 entries, assert rst_n=0 mid-stream → fft_valid=0, stall=0, cfg registers 0 asynchronously.
  - After release, first push appears as head.
